// File: rtl/out_ram_drain.sv
// rtl/out_ram_drain.sv - small write-addressed RAM with valid bits, drained in ascending address order
module out_ram_drain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              wr_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_err_q;
    logic              mem_we;
    logic              advance;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            valid_q  <= '0;
            count_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            wr_err_q <= write && (state_q != IDLE);
        end
    end

    // Storage is never reset: valid_q alone decides what is observable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr] <= data;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        count_d = count_q;
        mem_we  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (write) begin
                    mem_we = 1'b1;
                    if (!valid_q[addr]) begin
                        count_d = count_q + 1'b1;
                    end
                    valid_d[addr] = 1'b1;
                end
                if (start) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                // An invalid slot is skipped in one cycle; a valid one waits for the sink.
                if (valid_q[ptr_q]) begin
                    if (out_ready) begin
                        valid_d[ptr_q] = 1'b0;
                        count_d        = count_q - 1'b1;
                        advance        = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = rst_n && (state_q == DRAIN);
    assign done      = rst_n && (state_q == FIN);
    assign out_valid = busy && valid_q[ptr_q];
    assign out_data  = mem_q[ptr_q];
    assign out_addr  = ptr_q;
    assign count     = count_q;
    assign wr_err    = wr_err_q;

endmodule
